// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch and decode stages.
package rv32i_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RV32I_NOP      = 32'h0000_0013;
    localparam logic [31:0] RV32I_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one word read at a time and hands each instruction to
// decode over valid/ready. Redirects squash any in-flight or held instruction.
module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RV32I_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RV32I_NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    // An unacked request cannot be withdrawn; remember it so the address
                    // stays stable while we wait to throw its data away.
                    if (!imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = HOLD;
                end
            end
            DRAIN: begin
                if (redirect_valid) pc_d = redirect_target;
                if (imem_ack) state_d = FETCH;
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    if (redirect_valid) pc_d = redirect_target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign instruction = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;

endmodule
